// File: rtl/ripple_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ripple_pkg
// Description : Shared types and constants for the ripple counter and sampler.
// Revision    : 1.0 - initial release
// ============================================================================
package ripple_pkg;

    localparam int RIPPLE_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_STABLE = 2'd1,
        PRESENT     = 2'd2
    } sampler_state_t;

endpackage
`default_nettype wire

// File: rtl/ripple_count_sampler_sync_stable.sv
`default_nettype none
// ============================================================================
// Module      : sync_stable
// Description : Three-stage bus synchroniser with a "value settled" flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_stable
    import ripple_pkg::*;
#(
    parameter int WIDTH = RIPPLE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic             stable
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_sync3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= async_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // A ripple in flight shows up as consecutive synchronised samples differing.
    assign sync_out = r_sync2;
    assign stable   = (r_sync2 == r_sync3);

endmodule
`default_nettype wire

// File: rtl/ripple_count_sampler.sv
`default_nettype none
// ============================================================================
// Module      : ripple_count_sampler
// Description : Periodically captures a settled ripple-counter value with delta.
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_count_sampler
    import ripple_pkg::*;
#(
    parameter int WIDTH          = RIPPLE_WIDTH,
    parameter int SAMPLE_PERIOD  = 16,
    parameter int STABLE_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             enable,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_count,
    output logic [WIDTH-1:0] out_delta,
    output logic             out_forced,
    output logic             overrun
);

    localparam int TIMER_W = $clog2(SAMPLE_PERIOD);
    localparam int WAIT_W  = (STABLE_TIMEOUT > 1) ? $clog2(STABLE_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] C_TIMER_LAST = TIMER_W'(SAMPLE_PERIOD - 1);
    localparam logic [WAIT_W-1:0]  C_WAIT_LAST  = WAIT_W'(STABLE_TIMEOUT - 1);

    logic [WIDTH-1:0]   w_sync2;
    logic               w_stable;
    logic [TIMER_W-1:0] r_timer;
    logic               r_tick;
    logic [WAIT_W-1:0]  r_wait;
    logic [WIDTH-1:0]   r_prev_cap;
    sampler_state_t     r_state;
    sampler_state_t     w_state_next;
    logic               w_capture;
    logic               w_force;
    logic               w_handshake;

    sync_stable #(
        .WIDTH (WIDTH)
    ) u_sync_stable (
        .clk      (clk),
        .rst      (rst),
        .async_in (cnt_in),
        .sync_out (w_sync2),
        .stable   (w_stable)
    );

    // Tick is registered so it is a clean one-cycle pulse after the wrap edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (enable) begin
                if (r_timer == C_TIMER_LAST) begin
                    r_timer <= '0;
                    r_tick  <= 1'b1;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_force      = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_tick) begin
                    w_state_next = WAIT_STABLE;
                end
            end
            WAIT_STABLE: begin
                if (w_stable || (r_wait == C_WAIT_LAST)) begin
                    w_capture    = 1'b1;
                    w_force      = ~w_stable;
                    w_state_next = PRESENT;
                end
            end
            PRESENT: begin
                // out_valid is always high here, so ready alone completes the handshake.
                if (out_ready) begin
                    w_handshake  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait     <= '0;
            r_prev_cap <= '0;
            out_valid  <= 1'b0;
            out_count  <= '0;
            out_delta  <= '0;
            out_forced <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            r_wait <= (r_state == WAIT_STABLE) ? r_wait + 1'b1 : '0;
            if (w_capture) begin
                out_count  <= w_sync2;
                out_delta  <= w_sync2 - r_prev_cap;
                r_prev_cap <= w_sync2;
                out_forced <= w_force;
                out_valid  <= 1'b1;
            end else if (w_handshake) begin
                out_valid  <= 1'b0;
            end
            if (r_tick && (r_state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ripple_count_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ripple_count_sampler
// Description : Scoreboard bench for ripple_count_sampler with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ripple_count_sampler;

    localparam int W = 4;
    localparam logic [W-1:0] TOG_A = 4'd9;
    localparam logic [W-1:0] TOG_B = 4'd10;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] cnt_in;
    logic         enable;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_count;
    logic [W-1:0] out_delta;
    logic         out_forced;
    logic         overrun;

    always #5 clk = ~clk;

    ripple_count_sampler #(
        .WIDTH          (W),
        .SAMPLE_PERIOD  (16),
        .STABLE_TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .enable     (enable),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_count  (out_count),
        .out_delta  (out_delta),
        .out_forced (out_forced),
        .overrun    (overrun)
    );

    typedef struct {
        logic [W-1:0] count;
        logic [W-1:0] delta;
        logic         forced;
        logic         calc_delta;  // delta follows from the previous expected count
        logic         toggle_cnt;  // count is the toggled value three edges before capture
        int           phase;       // enabled-edge count mod 16 at the capture edge
    } exp_t;

    exp_t         sb_q[$];
    int           errors = 0;
    int           checks = 0;
    int           en_edges = 0;
    int           rise_phase = -1;
    logic [W-1:0] model_prev = '0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [W-1:0] c, input logic [W-1:0] d, input logic f,
                        input logic calc, input logic tog, input int ph);
        exp_t e;
        e.count      = c;
        e.delta      = d;
        e.forced     = f;
        e.calc_delta = calc;
        e.toggle_cnt = tog;
        e.phase      = ph;
        sb_q.push_back(e);
    endtask

    task automatic wait_empty(input string name);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 100) begin
            step(1);
            k++;
        end
        if (sb_q.size() != 0) begin
            check({name, "_timeout"}, sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    // Mirrors the sample timer's notion of time: enabled edges since reset.
    initial forever begin
        @(posedge clk);
        if (rst) en_edges = 0;
        else if (enable) en_edges = en_edges + 1;
    end

    initial begin : monitor
        logic         valid_q;
        exp_t         e;
        logic [W-1:0] exp_count;
        logic [W-1:0] exp_delta;
        valid_q = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && !valid_q) rise_phase = en_edges % 16;
            valid_q = out_valid;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_capture", int'(out_count), -1);
                end else begin
                    e = sb_q.pop_front();
                    exp_count = e.toggle_cnt ? ((cnt_in == TOG_A) ? TOG_B : TOG_A) : e.count;
                    exp_delta = e.calc_delta ? (exp_count - model_prev) : e.delta;
                    check("sb_count",  int'(out_count),  int'(exp_count));
                    check("sb_delta",  int'(out_delta),  int'(exp_delta));
                    check("sb_forced", int'(out_forced), int'(e.forced));
                    check("sb_phase",  rise_phase,       e.phase);
                    model_prev = exp_count;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int           bad;
        int           k;
        logic [W-1:0] held_count;
        logic [W-1:0] held_delta;

        rst       = 1'b1;
        enable    = 1'b0;
        cnt_in    = 4'd5;
        out_ready = 1'b1;
        step(3);
        check("reset_valid",   int'(out_valid), 0);
        check("reset_overrun", int'(overrun),   0);
        rst = 1'b0;

        // Idle with timer disabled: nothing may ever be presented.
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (out_valid || overrun) bad++;
        end
        check("idle_never_valid", bad, 0);
        check("idle_count",  int'(out_count),  0);
        check("idle_delta",  int'(out_delta),  0);
        check("idle_forced", int'(out_forced), 0);

        // Basic capture: first out_valid appears after enabled edge 18.
        cnt_in = 4'd6;
        step(4);
        push(4'd6, 4'd6, 1'b0, 1'b0, 1'b0, 2);
        enable = 1'b1;
        bad = 0;
        for (int i = 1; i <= 17; i++) begin
            step(1);
            if (out_valid) bad++;
        end
        check("early_valid", bad, 0);
        step(1);
        check("first_valid_latency", int'(out_valid), 1);
        wait_empty("basic1");
        push(4'd6, 4'd0, 1'b0, 1'b0, 1'b0, 2);
        wait_empty("basic2");

        // Wrap delta: 6 -> 14 -> 3 gives deltas 8 then 5.
        cnt_in = 4'd14;
        push(4'd14, 4'd8, 1'b0, 1'b0, 1'b0, 2);
        wait_empty("wrap14");
        cnt_in = 4'd3;
        push(4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 2);
        wait_empty("wrap3");

        // Forced capture: a never-settling input is taken after 8 wait cycles.
        cnt_in = TOG_A;
        push(4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 9);
        k = 0;
        while (sb_q.size() != 0 && k < 100) begin
            step(1);
            cnt_in = (cnt_in == TOG_A) ? TOG_B : TOG_A;
            k++;
        end
        if (sb_q.size() != 0) begin
            check("forced_timeout", sb_q.size(), 0);
            sb_q.delete();
        end

        // Backpressure: the capture is held unchanged and later ticks are dropped.
        cnt_in    = 4'd7;
        out_ready = 1'b0;
        push(4'd7, 4'd0, 1'b0, 1'b1, 1'b0, 2);
        k = 0;
        while (!out_valid && k < 40) begin
            step(1);
            k++;
        end
        check("bp_valid_rise",      int'(out_valid), 1);
        check("bp_count",           int'(out_count), 7);
        check("bp_overrun_before",  int'(overrun),   0);
        held_count = out_count;
        held_delta = out_delta;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (!out_valid || out_count != held_count || out_delta != held_delta) bad++;
        end
        check("bp_held", bad, 0);
        check("bp_overrun_after", int'(overrun), 1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        check("bp_released",       int'(out_valid),  0);
        check("bp_overrun_sticky", int'(overrun),    1);
        check("bp_consumed",       sb_q.size(),      0);

        // Reset while a capture is presented discards it and clears overrun.
        k = 0;
        while (!out_valid && k < 40) begin
            step(1);
            k++;
        end
        check("rm_valid",      int'(out_valid), 1);
        check("rm_cap_count",  int'(out_count), 7);
        check("rm_cap_delta",  int'(out_delta), 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rm_valid_cleared",   int'(out_valid), 0);
        check("rm_overrun_cleared", int'(overrun),   0);
        check("rm_count_cleared",   int'(out_count), 0);
        model_prev = '0;
        cnt_in     = 4'd11;
        out_ready  = 1'b1;
        push(4'd11, 4'd11, 1'b0, 1'b0, 1'b0, 2);
        wait_empty("after_reset");
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
